instr_mem_sync: RTL
===================

Name: instr_mem_sync

Overview:
- Parametrised, synchronous-read instruction memory for the pipelined LEGv8 core; successor to the fixed combinational program store.
- Sits between the IF-stage PC logic and the IF/ID register.
- Adds a runtime loader write port, one-cycle registered fetch with stall hold, and per-entry valid tracking.
- Unloaded or out-of-range locations return a safe default instruction.

Parameters:
- DATA_WIDTH, 32, instruction width in bits
- ADDR_WIDTH, 16, width of word-index address ports
- DEPTH, 64, number of instruction words physically stored (DEPTH <= 2^ADDR_WIDTH)
- DEFAULT_INSTR, 32'hD60003E0, word returned for unloaded or out-of-range addresses (BR XZR)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- fetch_req  input  1  fetch request from IF stage
- fetch_addr  input  ADDR_WIDTH  word index of instruction to fetch
- stall  input  1  pipeline stall; holds fetch outputs
- instr  output  DATA_WIDTH  registered fetched instruction
- instr_valid  output  1  instr holds the result of an accepted fetch
- fetch_oob  output  1  accepted fetch address was >= DEPTH
- ld_en  input  1  loader write enable
- ld_addr  input  ADDR_WIDTH  loader word index
- ld_data  input  DATA_WIDTH  loader instruction word
- ld_err  output  1  one-cycle pulse: rejected loader write
- mem_clr  input  1  synchronous invalidate of all entries
- loaded_cnt  output  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Reset (rst_n low, asynchronous, any cycle including mid-load or mid-fetch):
  - instr=DEFAULT_INSTR, instr_valid=0, fetch_oob=0, ld_err=0, loaded_cnt=0.
  - All DEPTH valid bits cleared. Storage array contents are not reset.
- Fetch acceptance: a fetch is accepted on a clk edge when fetch_req=1 and stall=0. Read latency is 1 cycle.
- Next-cycle outputs after an accepted fetch:
  - instr = stored word if fetch_addr < DEPTH and the entry is valid; otherwise DEFAULT_INSTR.
  - instr_valid=1.
  - fetch_oob = (fetch_addr >= DEPTH).
- stall=1: instr, instr_valid and fetch_oob hold their values; fetch_req is ignored.
- fetch_req=0 and stall=0: instr_valid=0 next cycle; instr and fetch_oob hold.
- Loader write:
  - On an edge with ld_en=1 and ld_addr < DEPTH: store ld_data and set that entry's valid bit.
  - ld_addr >= DEPTH: write dropped; ld_err=1 for exactly the next cycle, otherwise 0.
- loaded_cnt increments by 1 only when a write targets an entry that was not valid. Overwriting a valid entry leaves it unchanged. It never exceeds DEPTH.
- Same-cycle loader write and accepted fetch to the same in-range address are write-first: instr returns the new ld_data.
- mem_clr=1 on an edge: all valid bits cleared and loaded_cnt=0 next cycle.
- mem_clr has priority over a same-cycle ld_en:
  - The write is dropped with no ld_err.
  - A same-cycle accepted fetch returns DEFAULT_INSTR.
- ld_en is honoured regardless of stall.
- Address comparisons are unsigned and full ADDR_WIDTH; there is no wrap-around or modulo indexing.
- One always-block-style registered read port; storage must infer a synchronous RAM, with valid bits in flops.

Test Plan:
- Reset then fetch_req=1, fetch_addr=0 -> next cycle instr=32'hD60003E0, instr_valid=1, fetch_oob=0, loaded_cnt=0.
- Load addr0=32'hF8400081 and addr1=32'h8B000022, then fetch 0 and 1 back-to-back -> instr=F8400081 then 8B000022 on consecutive cycles; loaded_cnt=2; rewrite addr1 -> loaded_cnt stays 2.
- Fetch addr1, then stall=1 for 3 cycles while fetch_addr changes to 5 -> instr stays 8B000022, instr_valid=1; after release, the addr5 fetch yields D60003E0.
- ld_en with ld_addr=64 (DEPTH=64), then fetch 64 -> ld_err=1 for one cycle, loaded_cnt unchanged; fetch gives instr=D60003E0, fetch_oob=1.
- Same-cycle ld_en addr3=32'hF8000083 with fetch addr3 -> instr=F8000083 next cycle. Repeat the same cycle with mem_clr=1 -> instr=D60003E0, loaded_cnt=0, ld_err=0.
- Assert rst_n=0 mid-cycle during a load burst -> outputs reset immediately without waiting for clk; the post-reset fetch of a previously loaded address returns D60003E0.

Source files
------------

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory for the pipelined LEGv8 core.
// Sits between the IF-stage PC logic and the IF/ID register.
// Features: a runtime loader write port, a one-cycle registered fetch that
// holds on stall, and per-entry valid bits. Unloaded or out-of-range
// locations read back as DEFAULT_INSTR.
module instr_mem_sync #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    DEPTH         = 64,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_INSTR = 32'hD60003E0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_req,
  input  logic [ADDR_WIDTH-1:0]        fetch_addr,
  input  logic                         stall,
  output logic [DATA_WIDTH-1:0]        instr,
  output logic                         instr_valid,
  output logic                         fetch_oob,
  input  logic                         ld_en,
  input  logic [ADDR_WIDTH-1:0]        ld_addr,
  input  logic [DATA_WIDTH-1:0]        ld_data,
  output logic                         ld_err,
  input  logic                         mem_clr,
  output logic [$clog2(DEPTH+1)-1:0]   loaded_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW1   = ADDR_WIDTH + 1;

  // Output-mux source remembered from the accepted fetch.
  typedef enum logic [1:0] {SEL_DEF, SEL_RAM, SEL_BYP} sel_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ld_err_q, ld_err_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  fetch_oob_q, fetch_oob_d;
  sel_e                  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] byp_q, byp_d;

  logic             f_in, l_in, accept, wr_ok, hit;
  logic [IDX_W-1:0] f_idx, l_idx;

  // Full-width unsigned range checks; the extra bit keeps DEPTH == 2^ADDR_WIDTH legal.
  assign f_in   = ({1'b0, fetch_addr} < AW1'(DEPTH));
  assign l_in   = ({1'b0, ld_addr} < AW1'(DEPTH));
  assign f_idx  = fetch_addr[IDX_W-1:0];
  assign l_idx  = ld_addr[IDX_W-1:0];
  assign accept = fetch_req & ~stall;
  assign wr_ok  = ld_en & l_in & ~mem_clr;
  // A same-cycle write to the fetched word is forwarded, giving write-first behaviour.
  assign hit    = wr_ok & (ld_addr == fetch_addr);

  // Storage array: no reset, one write port and one registered read port.
  always_ff @(posedge clk) begin
    if (wr_ok)  mem[l_idx] <= ld_data;
    if (accept) rd_word    <= mem[f_idx];
  end

  // Valid bits, loaded count and loader error pulse.
  always_comb begin
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    ld_err_d = ld_en & ~l_in & ~mem_clr;
    if (mem_clr) begin
      valid_d = '0;
      cnt_d   = '0;
    end else if (wr_ok) begin
      valid_d[l_idx] = 1'b1;
      if (!valid_q[l_idx]) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Fetch side: choose the output source; stall freezes everything.
  always_comb begin
    sel_d         = sel_q;
    byp_d         = byp_q;
    instr_valid_d = instr_valid_q;
    fetch_oob_d   = fetch_oob_q;
    if (accept) begin
      instr_valid_d = 1'b1;
      fetch_oob_d   = ~f_in;
      if (mem_clr || !f_in) begin
        sel_d = SEL_DEF;
      end else if (hit) begin
        sel_d = SEL_BYP;
        byp_d = ld_data;
      end else if (valid_q[f_idx]) begin
        sel_d = SEL_RAM;
      end else begin
        sel_d = SEL_DEF;
      end
    end else if (!stall) begin
      instr_valid_d = 1'b0;
    end
  end

  // Control state; asynchronous reset returns outputs to their idle values at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      cnt_q         <= '0;
      ld_err_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_oob_q   <= 1'b0;
      sel_q         <= SEL_DEF;
      byp_q         <= '0;
    end else begin
      valid_q       <= valid_d;
      cnt_q         <= cnt_d;
      ld_err_q      <= ld_err_d;
      instr_valid_q <= instr_valid_d;
      fetch_oob_q   <= fetch_oob_d;
      sel_q         <= sel_d;
      byp_q         <= byp_d;
    end
  end

  // Output mux over the RAM read word, the forwarded write data and the default.
  always_comb begin
    instr = DEFAULT_INSTR;
    case (sel_q)
      SEL_RAM: instr = rd_word;
      SEL_BYP: instr = byp_q;
      default: instr = DEFAULT_INSTR;
    endcase
  end

  assign instr_valid = instr_valid_q;
  assign fetch_oob   = fetch_oob_q;
  assign ld_err      = ld_err_q;
  assign loaded_cnt  = cnt_q;

endmodule
